// File: rtl/adc_stream_receiver.sv
// adc_stream_receiver
//   AXI-Stream slave that stores ADC sample frames and hands out only complete
//   frames to the readout side. Words live in a data FIFO tagged with an
//   end-of-frame bit. Frame lengths live in a descriptor FIFO. A frame that
//   reaches DEPTH words without tlast is closed early and frame_split is set.
//
// Ports
//   aclk, areset        clock, synchronous active-high reset
//   s_axis_*            sample stream in: tdata[15:0]=ch A, [31:16]=ch B
//   rd_frame_valid/len  a complete frame is stored / its word count
//   rd_en               pop one word of the head frame
//   rd_data_valid       rd_data/rd_ch_a/rd_ch_b/rd_last valid (1 cycle after pop)
//   frames_rcvd         frames written (wraps)
//   words_rcvd          words accepted (wraps)
//   frame_split         sticky: a frame was force-terminated
module adc_stream_receiver #(
    parameter int AW     = 4,
    parameter int LEN_AW = 2
) (
    input  logic          aclk,
    input  logic          areset,
    input  logic [31:0]   s_axis_tdata,
    input  logic          s_axis_tvalid,
    input  logic          s_axis_tlast,
    output logic          s_axis_tready,
    output logic          rd_frame_valid,
    output logic [AW:0]   rd_frame_len,
    input  logic          rd_en,
    output logic          rd_data_valid,
    output logic [31:0]   rd_data,
    output logic [15:0]   rd_ch_a,
    output logic [15:0]   rd_ch_b,
    output logic          rd_last,
    output logic [31:0]   frames_rcvd,
    output logic [31:0]   words_rcvd,
    output logic          frame_split
);

    localparam int DEPTH  = 2**AW;
    localparam int LDEPTH = 2**LEN_AW;

    logic [32:0]       data_mem [DEPTH];
    logic [AW:0]       len_mem  [LDEPTH];

    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       data_cnt_q;
    logic [LEN_AW-1:0] lwr_ptr_q, lrd_ptr_q;
    logic [LEN_AW:0]   len_cnt_q;
    logic [AW:0]       cur_len_q;
    logic              tready_q;
    logic              rd_valid_q, rd_last_q;
    logic [31:0]       rd_data_q;
    logic [31:0]       frames_q, words_q;
    logic              split_q;

    logic accept, last_bit, forced, rd_ok, len_push, len_pop, tready_d;

    always_comb begin
        accept   = s_axis_tvalid && tready_q;
        forced   = (cur_len_q == (AW+1)'(DEPTH-1));
        last_bit = s_axis_tlast || forced;
        rd_ok    = rd_en && (len_cnt_q != '0);
        len_push = accept && last_bit;
        len_pop  = rd_ok && data_mem[rd_ptr_q][32];
        // Full is predicted from pushes only: a pop frees space but tready
        // rises one cycle later, which keeps the ready path short.
        tready_d = ((data_cnt_q + (AW+1)'(accept)) != (AW+1)'(DEPTH)) &&
                   ((len_cnt_q + (LEN_AW+1)'(len_push)) != (LEN_AW+1)'(LDEPTH));
    end

    always_ff @(posedge aclk) begin
        if (accept)
            data_mem[wr_ptr_q] <= {last_bit, s_axis_tdata};
        if (len_push)
            len_mem[lwr_ptr_q] <= cur_len_q + (AW+1)'(1);
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            data_cnt_q <= '0;
            lwr_ptr_q  <= '0;
            lrd_ptr_q  <= '0;
            len_cnt_q  <= '0;
            cur_len_q  <= '0;
            tready_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_data_q  <= '0;
            frames_q   <= '0;
            words_q    <= '0;
            split_q    <= 1'b0;
        end else begin
            tready_q   <= tready_d;
            rd_valid_q <= rd_ok;

            if (accept) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
                words_q  <= words_q + 32'd1;
                if (last_bit) begin
                    cur_len_q <= '0;
                    frames_q  <= frames_q + 32'd1;
                    if (!s_axis_tlast)
                        split_q <= 1'b1;
                end else begin
                    cur_len_q <= cur_len_q + (AW+1)'(1);
                end
            end

            if (rd_ok) begin
                rd_ptr_q  <= rd_ptr_q + AW'(1);
                rd_data_q <= data_mem[rd_ptr_q][31:0];
                rd_last_q <= data_mem[rd_ptr_q][32];
            end

            case ({accept, rd_ok})
                2'b10:   data_cnt_q <= data_cnt_q + (AW+1)'(1);
                2'b01:   data_cnt_q <= data_cnt_q - (AW+1)'(1);
                default: data_cnt_q <= data_cnt_q;
            endcase

            if (len_push)
                lwr_ptr_q <= lwr_ptr_q + LEN_AW'(1);
            if (len_pop)
                lrd_ptr_q <= lrd_ptr_q + LEN_AW'(1);
            case ({len_push, len_pop})
                2'b10:   len_cnt_q <= len_cnt_q + (LEN_AW+1)'(1);
                2'b01:   len_cnt_q <= len_cnt_q - (LEN_AW+1)'(1);
                default: len_cnt_q <= len_cnt_q;
            endcase
        end
    end

    assign s_axis_tready  = tready_q;
    assign rd_frame_valid = (len_cnt_q != '0);
    // Descriptor RAM is not reset; force zero while empty.
    assign rd_frame_len   = rd_frame_valid ? len_mem[lrd_ptr_q] : '0;
    assign rd_data_valid  = rd_valid_q;
    assign rd_data        = rd_data_q;
    assign rd_ch_a        = rd_data_q[15:0];
    assign rd_ch_b        = rd_data_q[31:16];
    assign rd_last        = rd_last_q;
    assign frames_rcvd    = frames_q;
    assign words_rcvd     = words_q;
    assign frame_split    = split_q;

endmodule

// File: tb/tb_adc_stream_receiver.sv
module tb_adc_stream_receiver;

    logic        aclk = 1'b0;
    logic        areset;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic        s_axis_tready;
    logic        rd_frame_valid;
    logic [4:0]  rd_frame_len;
    logic        rd_en;
    logic        rd_data_valid;
    logic [31:0] rd_data;
    logic [15:0] rd_ch_a;
    logic [15:0] rd_ch_b;
    logic        rd_last;
    logic [31:0] frames_rcvd;
    logic [31:0] words_rcvd;
    logic        frame_split;

    int chk_cnt = 0;
    int err_cnt = 0;

    always #5 aclk = ~aclk;

    adc_stream_receiver #(.AW(4), .LEN_AW(2)) dut (
        .aclk           (aclk),
        .areset         (areset),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tlast   (s_axis_tlast),
        .s_axis_tready  (s_axis_tready),
        .rd_frame_valid (rd_frame_valid),
        .rd_frame_len   (rd_frame_len),
        .rd_en          (rd_en),
        .rd_data_valid  (rd_data_valid),
        .rd_data        (rd_data),
        .rd_ch_a        (rd_ch_a),
        .rd_ch_b        (rd_ch_b),
        .rd_last        (rd_last),
        .frames_rcvd    (frames_rcvd),
        .words_rcvd     (words_rcvd),
        .frame_split    (frame_split)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the word was accepted.
    task automatic send(input logic [31:0] d, input logic l);
        int n = 0;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        while (!s_axis_tready && n < 100) begin
            @(negedge aclk);
            n++;
        end
        if (n >= 100) chk("send_timeout", 32'd0, 32'd1);
        @(negedge aclk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic read_word(input string tag, input logic [31:0] d, input logic l);
        rd_en = 1'b1;
        @(negedge aclk);
        rd_en = 1'b0;
        chk({tag, "_vld"},  {31'd0, rd_data_valid}, 32'd1);
        chk({tag, "_data"}, rd_data, d);
        chk({tag, "_last"}, {31'd0, rd_last}, {31'd0, l});
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_tready"}, {31'd0, s_axis_tready},  32'd0);
        chk({tag, "_fvalid"}, {31'd0, rd_frame_valid}, 32'd0);
        chk({tag, "_flen"},   {27'd0, rd_frame_len},   32'd0);
        chk({tag, "_dvalid"}, {31'd0, rd_data_valid},  32'd0);
        chk({tag, "_data"},   rd_data,                 32'd0);
        chk({tag, "_last"},   {31'd0, rd_last},        32'd0);
        chk({tag, "_frames"}, frames_rcvd,             32'd0);
        chk({tag, "_words"},  words_rcvd,              32'd0);
        chk({tag, "_split"},  {31'd0, frame_split},    32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        areset        = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        rd_en         = 1'b0;
        repeat (3) @(negedge aclk);
        check_reset_state("rst");
        areset = 1'b0;
        @(negedge aclk);
        chk("rst_tready_after", {31'd0, s_axis_tready}, 32'd1);

        // 1) five-word frame
        for (int i = 0; i < 5; i++)
            send({16'(2*i+2), 16'(2*i+1)}, i == 4);
        chk("t1_fvalid", {31'd0, rd_frame_valid}, 32'd1);
        chk("t1_flen",   {27'd0, rd_frame_len},   32'd5);
        for (int i = 0; i < 5; i++)
            read_word($sformatf("t1_rd%0d", i), {16'(2*i+2), 16'(2*i+1)}, i == 4);
        chk("t1_ch_a",   {16'd0, rd_ch_a}, 32'h0009);
        chk("t1_ch_b",   {16'd0, rd_ch_b}, 32'h000A);
        chk("t1_frames", frames_rcvd, 32'd1);
        chk("t1_words",  words_rcvd,  32'd5);
        chk("t1_empty",  {31'd0, rd_frame_valid}, 32'd0);

        // 2) partial frame is not readable
        for (int i = 0; i < 3; i++)
            send(32'hA000_0000 + 32'(i), 1'b0);
        rd_en = 1'b1;
        @(negedge aclk);
        rd_en = 1'b0;
        chk("t2_fvalid", {31'd0, rd_frame_valid}, 32'd0);
        chk("t2_dvalid", {31'd0, rd_data_valid},  32'd0);
        chk("t2_hold",   rd_data, 32'h000A_0009);
        send(32'hA000_0003, 1'b1);
        chk("t2_flen", {27'd0, rd_frame_len}, 32'd4);
        for (int i = 0; i < 4; i++)
            read_word($sformatf("t2_rd%0d", i), 32'hA000_0000 + 32'(i), i == 3);

        // 3) 20-word frame split at 16
        for (int i = 0; i < 16; i++)
            send(32'hB000_0000 + 32'(i), 1'b0);
        chk("t3_split",  {31'd0, frame_split},    32'd1);
        chk("t3_fvalid", {31'd0, rd_frame_valid}, 32'd1);
        chk("t3_flen",   {27'd0, rd_frame_len},   32'd16);
        chk("t3_full",   {31'd0, s_axis_tready},  32'd0);
        for (int i = 0; i < 16; i++)
            read_word($sformatf("t3_rd%0d", i), 32'hB000_0000 + 32'(i), i == 15);
        for (int i = 16; i < 20; i++)
            send(32'hB000_0000 + 32'(i), i == 19);
        chk("t3_flen2", {27'd0, rd_frame_len}, 32'd4);
        for (int i = 16; i < 20; i++)
            read_word($sformatf("t3_rd%0d", i), 32'hB000_0000 + 32'(i), i == 19);
        chk("t3_split_sticky", {31'd0, frame_split}, 32'd1);
        chk("t3_frames", frames_rcvd, 32'd4);
        chk("t3_words",  words_rcvd,  32'd29);

        // 4) descriptor FIFO full
        for (int i = 0; i < 4; i++)
            send(32'hC000_0000 + 32'(i), 1'b1);
        chk("t4_tready_full", {31'd0, s_axis_tready}, 32'd0);
        read_word("t4_rd0", 32'hC000_0000, 1'b1);
        chk("t4_tready_1cyc", {31'd0, s_axis_tready}, 32'd0);
        @(negedge aclk);
        chk("t4_tready_2cyc", {31'd0, s_axis_tready}, 32'd1);
        send(32'hC000_0004, 1'b1);
        for (int i = 1; i < 5; i++)
            read_word($sformatf("t4_rd%0d", i), 32'hC000_0000 + 32'(i), 1'b1);

        // 5) streaming: push and pop every cycle on 2-word frames
        send(32'h1000_2000, 1'b0);
        send(32'h1001_2001, 1'b1);
        for (int i = 2; i < 10; i++) begin
            s_axis_tdata  = {16'h1000 + 16'(i), 16'h2000 + 16'(i)};
            s_axis_tlast  = (i % 2) == 1;
            s_axis_tvalid = 1'b1;
            chk($sformatf("t5_tready%0d", i), {31'd0, s_axis_tready}, 32'd1);
            rd_en = 1'b1;
            @(negedge aclk);
            w = {16'h1000 + 16'(i-2), 16'h2000 + 16'(i-2)};
            chk($sformatf("t5_vld%0d", i),  {31'd0, rd_data_valid}, 32'd1);
            chk($sformatf("t5_data%0d", i), rd_data, w);
            chk($sformatf("t5_cha%0d", i),  {16'd0, rd_ch_a}, {16'd0, w[15:0]});
            chk($sformatf("t5_chb%0d", i),  {16'd0, rd_ch_b}, {16'd0, w[31:16]});
            chk($sformatf("t5_len%0d", i),  {27'd0, rd_frame_len}, 32'd2);
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        rd_en         = 1'b0;
        read_word("t5_tail0", 32'h1008_2008, 1'b0);
        read_word("t5_tail1", 32'h1009_2009, 1'b1);
        chk("t5_empty", {31'd0, rd_frame_valid}, 32'd0);

        // 6) reset mid-frame with a stored frame present
        send(32'hE000_00FF, 1'b1);
        send(32'hE000_0000, 1'b0);
        send(32'hE000_0001, 1'b0);
        areset = 1'b1;
        @(negedge aclk);
        check_reset_state("t6_rst");
        areset = 1'b0;
        @(negedge aclk);
        for (int i = 0; i < 6; i++)
            send(32'hF000_0000 + 32'(i), i == 5);
        chk("t6_flen", {27'd0, rd_frame_len}, 32'd6);
        for (int i = 0; i < 6; i++)
            read_word($sformatf("t6_rd%0d", i), 32'hF000_0000 + 32'(i), i == 5);
        chk("t6_empty",  {31'd0, rd_frame_valid}, 32'd0);
        chk("t6_frames", frames_rcvd, 32'd1);
        chk("t6_words",  words_rcvd,  32'd6);
        @(negedge aclk);
        chk("t6_dvalid_idle", {31'd0, rd_data_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
